// File: rtl/ex_stage_mdu.sv
// Execute stage for the pipelined RV32I core with an iterative RV32M unit.
// Single-cycle ALU, branch and jump resolution, plus a multi-cycle
// multiply/divide FSM that stalls the upstream stages until its result is
// ready. Results land in an EX/MEM register that holds under mem_stall.
module ex_stage_mdu #(
   parameter int unsigned     XLEN          = 32,
   parameter int unsigned     MUL_BITS      = 1,
   parameter logic [XLEN-1:0] RESET_PC_LINK = '0
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_func3,
   input  logic [6:0]      ex_func7,
   input  logic [4:0]      ex_rd_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            mem_stall,
   output logic            ex_stall,
   output logic            branch,
   output logic            flush,
   output logic [XLEN-1:0] pc_branch,
   output logic            exmem_valid,
   output logic [XLEN-1:0] exmem_alu_result,
   output logic [XLEN-1:0] exmem_data,
   output logic [4:0]      exmem_rd_addr,
   output logic [2:0]      exmem_func3,
   output logic            exmem_reg_write,
   output logic            exmem_mem_read,
   output logic            exmem_mem_write,
   output logic            exmem_mem_to_reg
);

   localparam int unsigned SHW   = $clog2(XLEN);
   localparam int unsigned CW    = $clog2(XLEN) + 1;
   localparam int unsigned MUL_N = XLEN / MUL_BITS;

   localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_N - 1);
   localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mdu_state_t;

   // ---------------------------------------------------------------- decode
   logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr;
   logic is_branch, is_load, is_store, is_mdu, writes_rd;

   assign is_op     = (ex_opcode == OPC_OP);
   assign is_opimm  = (ex_opcode == OPC_OPIMM);
   assign is_lui    = (ex_opcode == OPC_LUI);
   assign is_auipc  = (ex_opcode == OPC_AUIPC);
   assign is_jal    = (ex_opcode == OPC_JAL);
   assign is_jalr   = (ex_opcode == OPC_JALR);
   assign is_branch = (ex_opcode == OPC_BRANCH);
   assign is_load   = (ex_opcode == OPC_LOAD);
   assign is_store  = (ex_opcode == OPC_STORE);
   assign is_mdu    = is_op & (ex_func7 == 7'b0000001);
   assign writes_rd = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr | is_load;

   // ---------------------------------------------------------------- ALU
   logic [XLEN-1:0] op2, alu_res, sra_res;
   logic [SHW-1:0]  shamt;

   // Single-cycle integer ALU for register and immediate forms
   always_comb begin
      op2     = is_op ? rs2_data : ex_imm;
      shamt   = op2[SHW-1:0];
      sra_res = $signed(rs1_data) >>> shamt;
      alu_res = '0;
      case (ex_func3)
         3'b000:  alu_res = (is_op & ex_func7[5]) ? rs1_data - op2 : rs1_data + op2;
         3'b001:  alu_res = rs1_data << shamt;
         3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op2))};
         3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rs1_data < op2)};
         3'b100:  alu_res = rs1_data ^ op2;
         3'b101:  alu_res = ex_func7[5] ? sra_res : rs1_data >> shamt;
         3'b110:  alu_res = rs1_data | op2;
         default: alu_res = rs1_data & op2;
      endcase
   end

   // ---------------------------------------------------------------- MDU
   mdu_state_t      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] p_hi, p_lo, m_op, mdu_res;
   logic            neg_q, neg_r, op_mul;
   logic [1:0]      op_sel;

   logic            a_signed, b_signed, a_sgn, b_sgn;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] special_res;

   // Operand magnitudes, sign flags and the divide short-cut cases
   always_comb begin
      a_signed    = (ex_func3 == 3'b000) | (ex_func3 == 3'b001) | (ex_func3 == 3'b010)
                  | (ex_func3 == 3'b100) | (ex_func3 == 3'b110);
      b_signed    = (ex_func3 == 3'b000) | (ex_func3 == 3'b001)
                  | (ex_func3 == 3'b100) | (ex_func3 == 3'b110);
      a_sgn       = a_signed & rs1_data[XLEN-1];
      b_sgn       = b_signed & rs2_data[XLEN-1];
      a_mag       = a_sgn ? -rs1_data : rs1_data;
      b_mag       = b_sgn ? -rs2_data : rs2_data;
      div_zero    = ex_func3[2] & (rs2_data == '0);
      div_ovf     = ex_func3[2] & ~ex_func3[0] & (rs1_data == XMIN) & (rs2_data == '1);
      special_res = '0;
      if (div_zero)
         special_res = ex_func3[1] ? rs1_data : '1;
      else
         special_res = ex_func3[1] ? '0 : rs1_data;
   end

   // p_hi/p_lo are shared: product {hi,lo} for multiply, {remainder,quotient}
   // for divide, with p_lo shifting out multiplier digits / dividend bits.
   logic [XLEN+MUL_BITS-1:0] mul_sum;
   logic [XLEN:0]            r_sh, diff;
   logic [XLEN-1:0]          iter_hi, iter_lo, q_c, r_c, fin_res;
   logic [2*XLEN-1:0]        prod, prod_c;

   // One radix-2^MUL_BITS multiply step or one restoring divide step, plus
   // the sign-corrected final result taken from the last step's output
   always_comb begin
      mul_sum = {{MUL_BITS{1'b0}}, p_hi}
              + ({{MUL_BITS{1'b0}}, m_op} * {{XLEN{1'b0}}, p_lo[MUL_BITS-1:0]});
      r_sh    = {p_hi, p_lo[XLEN-1]};
      diff    = r_sh - {1'b0, m_op};
      if (op_mul) begin
         iter_hi = mul_sum[XLEN+MUL_BITS-1:MUL_BITS];
         iter_lo = {mul_sum[MUL_BITS-1:0], p_lo[XLEN-1:MUL_BITS]};
      end else if (!diff[XLEN]) begin
         iter_hi = diff[XLEN-1:0];
         iter_lo = {p_lo[XLEN-2:0], 1'b1};
      end else begin
         iter_hi = r_sh[XLEN-1:0];
         iter_lo = {p_lo[XLEN-2:0], 1'b0};
      end
      prod    = {iter_hi, iter_lo};
      prod_c  = neg_q ? -prod : prod;
      q_c     = neg_q ? -iter_lo : iter_lo;
      r_c     = neg_r ? -iter_hi : iter_hi;
      fin_res = '0;
      if (op_mul)
         fin_res = (op_sel == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
      else
         fin_res = op_sel[1] ? r_c : q_c;
   end

   // MDU sequencer: capture, iterate, hold result until EX/MEM accepts it
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state   <= S_IDLE;
         cnt     <= '0;
         p_hi    <= '0;
         p_lo    <= '0;
         m_op    <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         op_mul  <= 1'b0;
         op_sel  <= '0;
         mdu_res <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ex_valid & is_mdu) begin
                  op_mul <= ~ex_func3[2];
                  op_sel <= ex_func3[1:0];
                  neg_q  <= a_sgn ^ b_sgn;
                  neg_r  <= a_sgn;
                  cnt    <= '0;
                  if (div_zero | div_ovf) begin
                     mdu_res <= special_res;
                     state   <= S_DONE;
                  end else begin
                     p_hi  <= '0;
                     p_lo  <= ex_func3[2] ? a_mag : b_mag;
                     m_op  <= ex_func3[2] ? b_mag : a_mag;
                     state <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               p_hi <= iter_hi;
               p_lo <= iter_lo;
               cnt  <= cnt + CW'(1);
               if (cnt == (op_mul ? MUL_LAST : DIV_LAST)) begin
                  mdu_res <= fin_res;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               if (!mem_stall)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- control
   logic            adv, cond, taken;
   logic [XLEN-1:0] ex_result;

   assign ex_stall = rst_ & ((ex_valid & is_mdu & (state != S_DONE)) | mem_stall);
   assign adv      = rst_ & ex_valid & ~ex_stall;

   // Branch condition, redirect and final EX result selection
   always_comb begin
      case (ex_func3)
         3'b000:  cond = (rs1_data == rs2_data);
         3'b001:  cond = (rs1_data != rs2_data);
         3'b100:  cond = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  cond = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  cond = (rs1_data <  rs2_data);
         3'b111:  cond = (rs1_data >= rs2_data);
         default: cond = 1'b0;
      endcase
      taken     = (is_branch & cond) | is_jal | is_jalr;
      pc_branch = is_jalr ? ((rs1_data + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                          : (ex_pc + ex_imm);
      ex_result = ex_pc + ex_imm;
      if (is_lui)
         ex_result = ex_imm;
      else if (is_jal | is_jalr)
         ex_result = ex_pc + XLEN'(4);
      else if (is_load | is_store)
         ex_result = rs1_data + ex_imm;
      else if (is_mdu)
         ex_result = mdu_res;
      else if (is_op | is_opimm)
         ex_result = alu_res;
   end

   assign branch = adv & taken;
   assign flush  = branch;

   // EX/MEM pipeline register; holds every field while MEM is stalled
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         exmem_valid      <= 1'b0;
         exmem_alu_result <= RESET_PC_LINK;
         exmem_data       <= '0;
         exmem_rd_addr    <= '0;
         exmem_func3      <= '0;
         exmem_reg_write  <= 1'b0;
         exmem_mem_read   <= 1'b0;
         exmem_mem_write  <= 1'b0;
         exmem_mem_to_reg <= 1'b0;
      end else if (!mem_stall) begin
         exmem_valid      <= adv;
         exmem_alu_result <= ex_result;
         exmem_data       <= rs2_data;
         exmem_rd_addr    <= ex_rd_addr;
         exmem_func3      <= ex_func3;
         exmem_reg_write  <= adv & writes_rd;
         exmem_mem_read   <= adv & is_load;
         exmem_mem_write  <= adv & is_store;
         exmem_mem_to_reg <= adv & is_load;
      end
   end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Scoreboard bench for ex_stage_mdu: directed cases followed by random
// instructions, checked against an arithmetic reference model.
module tb_ex_stage_mdu;

   localparam int unsigned XL  = 32;
   localparam int unsigned MB  = 4;
   localparam logic [31:0] RPL = 32'h0000_1000;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef logic [63:0] w64;

   logic        clk = 1'b0;
   logic        rst_;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_imm, rs1_data, rs2_data;
   logic [6:0]  ex_opcode, ex_func7;
   logic [2:0]  ex_func3;
   logic [4:0]  ex_rd_addr;
   logic        mem_stall;
   logic        ex_stall, branch, flush;
   logic [31:0] pc_branch;
   logic        exmem_valid;
   logic [31:0] exmem_alu_result, exmem_data;
   logic [4:0]  exmem_rd_addr;
   logic [2:0]  exmem_func3;
   logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg;

   always #5 clk = ~clk;

   ex_stage_mdu #(.XLEN(XL), .MUL_BITS(MB), .RESET_PC_LINK(RPL)) dut (
      .clk(clk), .rst_(rst_), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
      .ex_rd_addr(ex_rd_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .mem_stall(mem_stall), .ex_stall(ex_stall), .branch(branch), .flush(flush),
      .pc_branch(pc_branch), .exmem_valid(exmem_valid),
      .exmem_alu_result(exmem_alu_result), .exmem_data(exmem_data),
      .exmem_rd_addr(exmem_rd_addr), .exmem_func3(exmem_func3),
      .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
      .exmem_mem_write(exmem_mem_write), .exmem_mem_to_reg(exmem_mem_to_reg)
   );

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [31:0] pc, imm, a, b;
   } ins_t;

   typedef struct {
      logic [31:0] res;
      bit          chk_res;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [3:0]  ctrl;   // {reg_write, mem_read, mem_write, mem_to_reg}
   } exp_t;

   exp_t scb[$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input w64 act, input w64 req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   function automatic ins_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] a, input logic [31:0] b);
      ins_t i;
      i.opc = opc; i.f3 = f3; i.f7 = f7; i.rd = rd; i.pc = pc; i.imm = imm; i.a = a; i.b = b;
      return i;
   endfunction

   // ---------------------------------------------------------- reference model
   function automatic bit is_mdu_ins(input ins_t i);
      return (i.opc == OPC_OP) && (i.f7 == 7'b0000001);
   endfunction

   function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, p;
      bit          ovf;
      sa  = {{32{a[31]}}, a};
      ua  = {32'b0, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'b0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf)    return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] ref_result(input ins_t i);
      logic [31:0] o2;
      int unsigned sh;
      o2 = (i.opc == OPC_OP) ? i.b : i.imm;
      sh = o2 % 32;
      case (i.opc)
         OPC_LUI:             return i.imm;
         OPC_AUIPC:           return i.pc + i.imm;
         OPC_JAL, OPC_JALR:   return i.pc + 32'd4;
         OPC_LOAD, OPC_STORE: return i.a + i.imm;
         OPC_OP, OPC_OPIMM: begin
            if (is_mdu_ins(i)) return mdu_ref(i.f3, i.a, i.b);
            case (i.f3)
               3'd0: return (i.opc == OPC_OP && i.f7[5]) ? i.a - o2 : i.a + o2;
               3'd1: return i.a << sh;
               3'd2: return ($signed(i.a) < $signed(o2)) ? 32'd1 : 32'd0;
               3'd3: return (i.a < o2) ? 32'd1 : 32'd0;
               3'd4: return i.a ^ o2;
               3'd5: return i.f7[5] ? 32'($signed(i.a) >>> sh) : i.a >> sh;
               3'd6: return i.a | o2;
               default: return i.a & o2;
            endcase
         end
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit taken_ref(input ins_t i);
      if (i.opc == OPC_JAL || i.opc == OPC_JALR) return 1'b1;
      if (i.opc != OPC_BRANCH) return 1'b0;
      case (i.f3)
         3'd0: return i.a == i.b;
         3'd1: return i.a != i.b;
         3'd4: return $signed(i.a) <  $signed(i.b);
         3'd5: return $signed(i.a) >= $signed(i.b);
         3'd6: return i.a <  i.b;
         3'd7: return i.a >= i.b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] target_ref(input ins_t i);
      if (i.opc == OPC_JALR) return (i.a + i.imm) & 32'hFFFF_FFFE;
      return i.pc + i.imm;
   endfunction

   function automatic int exp_stall(input ins_t i);
      if (!is_mdu_ins(i)) return 0;
      if (!i.f3[2]) return XL / MB + 1;
      if (i.b == 0) return 1;
      if ((i.f3 == 3'd4 || i.f3 == 3'd6) && i.a == 32'h8000_0000 && i.b == 32'hFFFF_FFFF) return 1;
      return XL + 1;
   endfunction

   function automatic exp_t exp_of(input ins_t i);
      exp_t e;
      bit   wr;
      wr = (i.opc == OPC_OP) || (i.opc == OPC_OPIMM) || (i.opc == OPC_LUI) || (i.opc == OPC_AUIPC)
        || (i.opc == OPC_JAL) || (i.opc == OPC_JALR) || (i.opc == OPC_LOAD);
      e.res     = ref_result(i);
      e.chk_res = (i.opc != OPC_BRANCH);
      e.data    = i.b;
      e.rd      = i.rd;
      e.f3      = i.f3;
      e.ctrl    = {wr, i.opc == OPC_LOAD, i.opc == OPC_STORE, i.opc == OPC_LOAD};
      return e;
   endfunction

   // ---------------------------------------------------------- driver
   task automatic drive(input ins_t i);
      ex_opcode = i.opc; ex_func3 = i.f3; ex_func7 = i.f7; ex_rd_addr = i.rd;
      ex_pc = i.pc; ex_imm = i.imm; rs1_data = i.a; rs2_data = i.b;
   endtask

   task automatic issue(input ins_t i, input int ms_pre);
      int stalls;
      bit tk;
      drive(i);
      ex_valid = 1'b1;
      for (int k = 0; k < ms_pre; k++) begin
         mem_stall = 1'b1;
         @(negedge clk);
         chk("stall_on_mem", w64'(ex_stall), w64'(1));
         chk("branch_held", w64'(branch), w64'(0));
         @(posedge clk); #1;
      end
      mem_stall = 1'b0;
      stalls = 0;
      forever begin
         @(negedge clk);
         if (!ex_stall) break;
         stalls++;
         if (stalls > 200) begin
            n_total++;
            $display("FAIL stall_timeout: actual=%0d cycles required=%0d", stalls, exp_stall(i));
            break;
         end
         @(posedge clk); #1;
      end
      chk("stall_len", w64'(stalls), w64'(exp_stall(i)));
      tk = taken_ref(i);
      chk("branch", w64'(branch), w64'(tk));
      chk("flush", w64'(flush), w64'(tk));
      if (tk) chk("pc_branch", w64'(pc_branch), w64'(target_ref(i)));
      scb.push_back(exp_of(i));
      @(posedge clk); #1;
      ex_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   function automatic ins_t rand_ins();
      logic [2:0] bf [6];
      ins_t       i;
      bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      i = mk(OPC_OP, 3'($urandom_range(0, 7)), ($urandom_range(0, 1) != 0) ? 7'b0100000 : 7'b0,
             5'($urandom_range(1, 31)), $urandom & 32'hFFFF_FFFC, $urandom, pick_val(), pick_val());
      case ($urandom_range(0, 11))
         0, 1:  i.opc = OPC_OP;
         2, 3:  i.opc = OPC_OPIMM;
         4:     begin i.opc = OPC_LUI; i.imm = i.imm & 32'hFFFF_F000; end
         5:     i.opc = OPC_AUIPC;
         6:     i.opc = OPC_JAL;
         7:     i.opc = OPC_JALR;
         8:     begin i.opc = OPC_BRANCH; i.f3 = bf[$urandom_range(0, 5)]; end
         9:     i.opc = OPC_LOAD;
         10:    i.opc = OPC_STORE;
         default: begin i.opc = OPC_OP; i.f7 = 7'b0000001; end
      endcase
      return i;
   endfunction

   // ---------------------------------------------------------- monitor
   initial begin : monitor
      logic  ms_prev, rst_prev;
      w64    snap_lo, snap_res;
      exp_t  e;
      ms_prev  = 1'b1;
      rst_prev = 1'b0;
      snap_lo  = '0;
      snap_res = '0;
      forever begin
         @(negedge clk);
         if (rst_ && rst_prev) begin
            if (!ms_prev) begin
               if (exmem_valid) begin
                  if (scb.size() == 0) begin
                     n_total++;
                     $display("FAIL unexpected_valid: actual=1 required=0 (no pending instruction)");
                  end else begin
                     e = scb.pop_front();
                     if (e.chk_res) chk("result", w64'(exmem_alu_result), w64'(e.res));
                     chk("data", w64'(exmem_data), w64'(e.data));
                     chk("rd_addr", w64'(exmem_rd_addr), w64'(e.rd));
                     chk("func3", w64'(exmem_func3), w64'(e.f3));
                     chk("ctrl", w64'({exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}),
                         w64'(e.ctrl));
                  end
               end else begin
                  chk("bubble_ctrl", w64'({exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}),
                      w64'(0));
               end
            end else begin
               chk("hold_fields", w64'({exmem_valid, exmem_data, exmem_rd_addr, exmem_func3, exmem_reg_write,
                                        exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}), snap_lo);
               chk("hold_result", w64'(exmem_alu_result), snap_res);
            end
         end
         snap_lo  = w64'({exmem_valid, exmem_data, exmem_rd_addr, exmem_func3, exmem_reg_write,
                          exmem_mem_read, exmem_mem_write, exmem_mem_to_reg});
         snap_res = w64'(exmem_alu_result);
         ms_prev  = mem_stall;
         rst_prev = rst_;
      end
   end

   // ---------------------------------------------------------- watchdog
   initial begin : watchdog
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

   // ---------------------------------------------------------- stimulus
   initial begin : stim
      int   drain;
      ins_t i;
      rst_      = 1'b0;
      mem_stall = 1'b1;
      ex_valid  = 1'b1;
      drive(mk(OPC_OP, 3'd4, 7'b0000001, 5'd1, 32'h0, 32'h0, 32'd9, 32'd3));
      #12;
      chk("rst_exmem_valid", w64'(exmem_valid), w64'(0));
      chk("rst_result", w64'(exmem_alu_result), w64'(RPL));
      chk("rst_ctrl", w64'({exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}), w64'(0));
      chk("rst_ex_stall", w64'(ex_stall), w64'(0));
      chk("rst_branch", w64'(branch), w64'(0));
      ex_valid  = 1'b0;
      mem_stall = 1'b0;
      @(negedge clk); #1 rst_ = 1'b1;
      @(posedge clk); #1;

      issue(mk(OPC_OP, 3'd0, 7'b0, 5'd3, 32'h100, 32'h0, 32'd10, 32'd20), 0);
      issue(mk(OPC_OP, 3'd0, 7'b0000001, 5'd4, 32'h104, 32'h0, 32'd7, 32'hFFFF_FFFD), 0);
      issue(mk(OPC_OP, 3'd3, 7'b0000001, 5'd5, 32'h108, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0);
      issue(mk(OPC_OP, 3'd4, 7'b0000001, 5'd6, 32'h10C, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF), 0);
      issue(mk(OPC_OP, 3'd6, 7'b0000001, 5'd7, 32'h110, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF), 0);
      issue(mk(OPC_OP, 3'd5, 7'b0000001, 5'd8, 32'h114, 32'h0, 32'd100, 32'd0), 0);
      issue(mk(OPC_OP, 3'd7, 7'b0000001, 5'd9, 32'h118, 32'h0, 32'd100, 32'd0), 0);
      issue(mk(OPC_BRANCH, 3'd0, 7'b0, 5'd0, 32'h2000, 32'd16, 32'd5, 32'd5), 2);
      issue(mk(OPC_JALR, 3'd0, 7'b0, 5'd1, 32'h0400, 32'd4, 32'h3001, 32'd0), 0);

      // reset in the middle of a long divide
      drive(mk(OPC_OP, 3'd4, 7'b0000001, 5'd10, 32'h500, 32'h0, 32'd1000, 32'd3));
      ex_valid = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk); #1 rst_ = 1'b0;
      #1;
      chk("midrst_ex_stall", w64'(ex_stall), w64'(0));
      chk("midrst_exmem_valid", w64'(exmem_valid), w64'(0));
      chk("midrst_result", w64'(exmem_alu_result), w64'(RPL));
      ex_valid = 1'b0;
      @(negedge clk); #1 rst_ = 1'b1;
      @(posedge clk); #1;
      issue(mk(OPC_OP, 3'd5, 7'b0000001, 5'd11, 32'h600, 32'h0, 32'd100, 32'd7), 0);

      for (int n = 0; n < 80; n++) begin
         i = rand_ins();
         issue(i, (is_mdu_ins(i) || $urandom_range(0, 3) != 0) ? 0 : int'($urandom_range(1, 2)));
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) begin
            @(posedge clk); #1;
         end
      end

      drain = 0;
      while (scb.size() != 0 && drain < 50) begin
         @(posedge clk); #1;
         drain++;
      end
      repeat (2) @(posedge clk);
      chk("scoreboard_drained", w64'(scb.size()), w64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
